// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start-bit centring, LSB-first data,
// stop-bit check, one-cycle done strobe.
module uart_rx #(
  parameter int data_bits  = 8,
  parameter int stop_ticks = 16,
  parameter int num_ticks  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick,
  output logic [data_bits-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int SMAX = (stop_ticks > num_ticks) ? stop_ticks : num_ticks;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(data_bits);

  localparam logic [SW-1:0] S_MID  = SW'(num_ticks / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(num_ticks - 1);
  localparam logic [SW-1:0] S_STOP = SW'(stop_ticks - 1);
  localparam logic [NW-1:0] N_LAST = NW'(data_bits - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [data_bits-1:0] b;
  logic                 rx_m;
  logic                 rx_s;

  // Idle-high line: synchronizer resets to 1 so reset never fakes a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      frame_error  <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[data_bits-1:1]};
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == S_STOP) begin
              dout         <= b;
              frame_error  <= ~rx_s;
              rx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx; expected frames come from
// a byte/stop-bit queue model, observed frames from a done-strobe monitor.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_error;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic       prev_done = 1'b0;
  logic [1:0] tcnt = 2'd0;

  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .tick         (tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt <= tcnt + 2'd1;
    tick <= (tcnt == 2'd3);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done_tick) begin
        obs_q.push_back({frame_error, dout});
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (prev_done) chk("done_width", 32'(rx_done_tick), 32'd0);
      prev_done = rx_done_tick;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // nbits < 8 stops after that many data bits, leaving the frame open
  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input int nbits);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (nbits == 8) begin
      if (stop_ok) begin
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
      end else begin
        // low across the stop sample point, then high early so the
        // stuck-low tail is rejected as a start glitch
        rx = 1'b0;
        repeat (48) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
      end
      exp_q.push_back({~stop_ok, d});
    end
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [8:0] o;
      logic [8:0] e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_dout"}, 32'(o[7:0]), 32'(e[7:0]));
      chk({tag, "_ferr"}, 32'(o[8]), 32'(e[8]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    bit         saw_busy;
    logic [7:0] rb;
    bit         rok;

    // reset
    reset = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_done", 32'(rx_done_tick), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(1000);
    chk("idle_dout", 32'(dout), 32'h00);
    chk("idle_ferr", 32'(frame_error), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_frames", 32'(obs_q.size()), 32'd0);

    // single frame
    send_frame(8'hA5, 1'b1, 8);
    idle(200);
    chk("a5_busy", 32'(busy), 32'd0);
    check_frames("a5");

    // start glitch
    held = dout;
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", 32'(saw_busy), 32'd1);
    idle(100);
    chk("glitch_busy_end", 32'(busy), 32'd0);
    chk("glitch_dout", 32'(dout), 32'(held));
    check_frames("glitch");

    // bad stop bit then recovery
    send_frame(8'h3C, 1'b0, 8);
    idle(200);
    send_frame(8'h81, 1'b1, 8);
    idle(200);
    check_frames("badstop");

    // reset mid-frame
    send_frame(8'hFF, 1'b1, 4);
    reset = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dout", 32'(dout), 32'h00);
    reset = 1'b0;
    idle(50);
    send_frame(8'h5A, 1'b1, 8);
    idle(200);
    check_frames("midrst");

    // back-to-back
    send_frame(8'h00, 1'b1, 8);
    send_frame(8'hFF, 1'b1, 8);
    idle(200);
    check_frames("b2b");

    // randomized frames
    for (int k = 0; k < 8; k++) begin
      rb  = 8'($urandom_range(255, 0));
      rok = ($urandom_range(3, 0) != 0);
      send_frame(rb, rok, 8);
      if (rok) idle($urandom_range(60, 0));
      else idle(100 + $urandom_range(60, 0));
    end
    idle(200);
    chk("rand_busy", 32'(busy), 32'd0);
    check_frames("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
